// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, imem request FSM,
// decode hand-off register with stall, squash and redirect handling.
module fetch_ctrl #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc_F,
  input  logic [N-1:0] PCBranch_F,
  input  logic         stall_D,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic         imem_req,
  output logic [N-1:0] imem_addr_F,
  output logic [31:0]  instr_D,
  output logic         valid_D,
  output logic [31:0]  fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  // Next-state logic; a redirect always wins over stall and ready.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (PCSrc_F) pc_d = PCBranch_F;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (PCSrc_F) begin
          pc_d    = PCBranch_F;
          state_d = imem_ready ? S_REQ : S_FLUSH;
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          pc_d    = pc_q + N'(4);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (PCSrc_F) begin
          valid_d = 1'b0;
          pc_d    = PCBranch_F;
          state_d = S_REQ;
        end else if (!stall_D) begin
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          state_d = S_REQ;
        end
      end
      S_FLUSH: begin
        if (PCSrc_F) pc_d = PCBranch_F;
        if (imem_ready) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr_F = pc_q;
  assign instr_D     = instr_q;
  assign valid_D     = valid_q;
  assign fetch_count = count_q;

endmodule
